fifo_sync_param: RTL and testbench
==================================

// Module: fifo_sync_param
// PURPOSE
// - Parametrised synchronous FIFO with integrated register-array storage.
// - Supports full 2**ADDR_WIDTH occupancy, simultaneous push/pop, and almost-full/almost-empty flags.
// - Sticky overflow/underflow error flags; selectable standard (registered) or first-word-fall-through read mode.
// - Drop-in buffer between producer/consumer stages in lab datapaths.
// PARAMETERS
// - DATA_WIDTH  8   bits per entry
// - ADDR_WIDTH  4   pointer width; DEPTH = 2**ADDR_WIDTH entries
// - AF_THRESH   14  almost_full asserted when count >= AF_THRESH (1..DEPTH)
// - AE_THRESH   1   almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
// - FWFT        0   0 = standard registered read; 1 = first-word-fall-through
// PORTS
// - clk           in   1             clock, all state on rising edge
// - reset         in   1             asynchronous, active-high
// - wr_en         in   1             push request
// - wr_data       in   DATA_WIDTH    push data
// - rd_en         in   1             pop request
// - clr_err       in   1             synchronous clear of overflow/underflow
// - rd_data       out  DATA_WIDTH    read data (timing per FWFT)
// - rd_valid      out  1             rd_data holds a popped word
// - count         out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
// - empty, full   out  1             count==0 / count==DEPTH
// - almost_empty  out  1             count <= AE_THRESH
// - almost_full   out  1             count >= AF_THRESH
// - overflow      out  1             sticky: wr_en while push rejected
// - underflow     out  1             sticky: rd_en while empty
// BEHAVIOUR
// - Reset (async): rd_ptr=wr_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=underflow=0.
//   Outputs after reset: empty=1, full=0, almost_empty=1, almost_full=0.
//   Storage contents are not cleared; reset mid-operation discards all queued entries.
// - pop_ok  = rd_en && !empty.
// - push_ok = wr_en && (!full || pop_ok); a simultaneous pop frees the slot when full.
// - push_ok: mem[wr_ptr] <= wr_data; wr_ptr <= wr_ptr+1, natural wrap at DEPTH-1 -> 0.
// - pop_ok: rd_ptr <= rd_ptr+1, natural wrap.
// - count: +1 on push only, -1 on pop only, unchanged on both; never leaves 0..DEPTH.
// - Empty with simultaneous rd_en & wr_en: push accepted, pop rejected, underflow set, count -> 1.
// - FWFT=0: on pop_ok, rd_data <= mem[rd_ptr] and rd_valid=1 next cycle (1-cycle latency).
//   With no pop, rd_valid=0 and rd_data holds its last value.
// - FWFT=1: rd_data = mem[rd_ptr] combinationally; rd_valid = !empty; rd_en acknowledges the head word.
// - Flags are decoded from registered count, so they change the cycle after the push/pop edge.
// - overflow <= 1 when wr_en && !push_ok; underflow <= 1 when rd_en && empty.
//   Both cleared by clr_err. Set wins over clear in the same cycle.
// STRUCTURE
// - Package fifo_pkg: fifo_status_t packed struct {empty, full, almost_empty, almost_full, overflow, underflow}.
//   Also holds helper function fifo_depth(addr_w).
// - Sub-module fifo_regfile: DEPTH x DATA_WIDTH array, synchronous write, asynchronous read, no reset.
// - Top contains pointers, count, flag logic and the read register.
// TESTING
// - Reset, then 16 pushes of 0x00..0x0F -> full=1 and count=16 after last edge; almost_full rises when count reaches 14.
// - Push a 17th word while full -> rejected, overflow=1, count stays 16; clr_err -> overflow=0.
// - Pop 16 with FWFT=0 -> rd_data 0x00..0x0F in order, each one cycle after its rd_en edge; empty=1 at end.
// - While full, assert rd_en and wr_en (0xAA) together -> count stays 16, 0xAA is read last after wrap.
// - While empty, assert rd_en and wr_en (0x55) together -> underflow=1, count=1; FWFT=1 shows rd_data=0x55 with rd_valid=1.
// - Assert reset with count=7 mid-stream -> empty=1, count=0, rd_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO.
package fifo_pkg;

  // Decoded status, one bit per externally visible flag.
  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  // Number of entries addressed by a pointer of the given width.
  function automatic int unsigned fifo_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// Storage array for the FIFO: synchronous write, asynchronous read, no reset.
module fifo_regfile
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with occupancy flags, sticky error flags and
// selectable registered or first-word-fall-through read.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_THRESH  = 14,
  parameter int unsigned AE_THRESH  = 1,
  parameter int unsigned FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned           DEPTH     = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_CNT    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0]   AE_CNT    = (ADDR_WIDTH+1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  push_ok, pop_ok;
  logic [DATA_WIDTH-1:0] head;
  fifo_status_t          status;

  fifo_regfile #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_regfile (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  // Flags decode from the registered count, so they trail the push/pop edge by one cycle.
  always_comb begin
    status              = '0;
    status.empty        = (count_q == '0);
    status.full         = (count_q == DEPTH_CNT);
    status.almost_empty = (count_q <= AE_CNT);
    status.almost_full  = (count_q >= AF_CNT);
    status.overflow     = overflow_q;
    status.underflow    = underflow_q;
  end

  // A pop in the same cycle frees a slot, so a full FIFO still accepts a push.
  always_comb begin
    pop_ok  = rd_en && !status.empty;
    push_ok = wr_en && (!status.full || pop_ok);
  end

  // Next-state for pointers, occupancy and sticky errors; set beats clear.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en && !push_ok) begin
      overflow_d = 1'b1;
    end
    if (rd_en && status.empty) begin
      underflow_d = 1'b1;
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is presented directly; rd_en only acknowledges it.
    always_comb begin
      rd_data  = head;
      rd_valid = !status.empty;
    end
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    // Registered read: popped word appears one cycle after the pop edge.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= pop_ok;
        if (pop_ok) begin
          rd_data_q <= head;
        end
      end
    end

    always_comb begin
      rd_data  = rd_data_q;
      rd_valid = rd_valid_q;
    end
  end

  // Drive flag ports from the decoded status.
  always_comb begin
    count        = count_q;
    empty        = status.empty;
    full         = status.full;
    almost_empty = status.almost_empty;
    almost_full  = status.almost_full;
    overflow     = status.overflow;
    underflow    = status.underflow;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param: a registered-read instance is checked by a
// negedge monitor against a queue of expected words; a FWFT instance shares the stimulus.
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;

  logic [7:0] rd_data0, rd_data1;
  logic       rd_valid0, rd_valid1;
  logic [4:0] count0, count1;
  logic       empty0, full0, ae0, af0, ovf0, unf0;
  logic       empty1, full1, ae1, af1, ovf1, unf1;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];   // words the registered instance must present, in order
  logic [7:0] model[$];   // current FIFO contents

  always #5 clk = ~clk;

  fifo_sync_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_THRESH(14), .AE_THRESH(1), .FWFT(0)) dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .clr_err(clr_err), .rd_data(rd_data0), .rd_valid(rd_valid0), .count(count0),
    .empty(empty0), .full(full0), .almost_empty(ae0), .almost_full(af0),
    .overflow(ovf0), .underflow(unf0)
  );

  fifo_sync_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_THRESH(14), .AE_THRESH(1), .FWFT(1)) dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .clr_err(clr_err), .rd_data(rd_data1), .rd_valid(rd_valid1), .count(count1),
    .empty(empty1), .full(full1), .almost_empty(ae1), .almost_full(af1),
    .overflow(ovf1), .underflow(unf1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock with the given inputs; updates the expected-read queue beforehand.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic c);
    bit m_pop, m_push;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    clr_err = c;
    m_pop  = r && (model.size() > 0);
    m_push = w && ((model.size() < 16) || m_pop);
    if (m_pop) exp_q.push_back(model.pop_front());
    if (m_push) model.push_back(d);
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
  endtask

  // Monitor: every word presented by the registered instance must match the queue head.
  always @(negedge clk) begin
    if (!reset && rd_valid0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_data_unexpected: got %0h expected no word", rd_data0);
      end else begin
        chk("rd_data_order", {24'h0, rd_data0}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    // Reset state
    #1 reset = 1'b1;
    #1;
    chk("rst_empty", empty0, 1);
    chk("rst_full", full0, 0);
    chk("rst_ae", ae0, 1);
    chk("rst_af", af0, 0);
    chk("rst_count", count0, 0);
    chk("rst_valid", rd_valid0, 0);
    chk("rst_rd_data", rd_data0, 8'h00);
    chk("rst_ovf", ovf0, 0);
    chk("rst_unf", unf0, 0);
    chk("rst_fwft_valid", rd_valid1, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_count", count0, i + 1);
      chk("fill_af", af0, (i + 1 >= 14) ? 1 : 0);
      chk("fill_ae", ae0, (i + 1 <= 1) ? 1 : 0);
      chk("fill_full", full0, (i == 15) ? 1 : 0);
      chk("fill_valid", rd_valid0, 0);
    end
    chk("fill_empty", empty0, 0);
    chk("fwft_head_valid", rd_valid1, 1);
    chk("fwft_head_data", rd_data1, 8'h00);

    // Overflow on a 17th push, then clear
    cycle(1'b1, 8'h99, 1'b0, 1'b0);
    chk("ovf_set", ovf0, 1);
    chk("ovf_count", count0, 16);
    chk("ovf_full", full0, 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", ovf0, 0);

    // Drain 16 words; monitor checks order, here check latency and flags
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("pop_valid_latency", rd_valid0, 1);
      chk("pop_data_latency", rd_data0, 8'(i));
      chk("pop_count", count0, 15 - i);
    end
    chk("drain_empty", empty0, 1);
    chk("drain_ae", ae0, 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("idle_valid", rd_valid0, 0);
    chk("idle_hold", rd_data0, 8'h0F);

    // Refill, then simultaneous push/pop while full
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    chk("refill_full", full0, 1);
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("both_full_count", count0, 16);
    chk("both_full_ovf", ovf0, 0);
    chk("both_full_data", rd_data0, 8'h10);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("wrap_last", rd_data0, 8'hAA);
    chk("wrap_empty", empty0, 1);

    // Simultaneous push/pop while empty
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    chk("both_empty_unf", unf0, 1);
    chk("both_empty_count", count0, 1);
    chk("both_empty_valid", rd_valid0, 0);
    chk("fwft_55_data", rd_data1, 8'h55);
    chk("fwft_55_valid", rd_valid1, 1);
    chk("fwft_55_unf", unf1, 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft_after_pop_valid", rd_valid1, 0);
    // Underflow set wins over clear
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    chk("unf_set_wins", unf0, 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("unf_clr", unf0, 0);

    // Asynchronous reset mid-stream with 7 queued
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_rst_count", count0, 7);
    chk("pre_rst_valid", rd_valid0, 1);
    @(negedge clk);
    #1 reset = 1'b1;
    model.delete();
    #1;
    chk("arst_empty", empty0, 1);
    chk("arst_count", count0, 0);
    chk("arst_valid", rd_valid0, 0);
    chk("arst_fwft_valid", rd_valid1, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("post_rst_empty", empty0, 1);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
